calc_cmd_sequencer: RTL and testbench

Command sequencer between the keypad decoder and the calculator core. It buffers key codes in a small FIFO and issues them one at a time on the core's 4-bit `cmd` port, only while the core reports ready. It holds each code stable until the core acknowledges by going busy, then drives the idle code. It also latches the core's error status and flushes pending keys.

---
 rtl/calc_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: buffers keypad codes in a FIFO and hands them one at a time to the calculator core.
// Ports: clock/reset (async, active-high); key_valid/key_code/key_ready form the key FIFO push side;
// core_status/err_clear come from the core and the operator; cmd is the code driven to the core;
// seq_busy, err, overflow and dropped are registered status outputs.
// Optional: define CMDSEQ_TIMEOUT_EN to drop a code the core never acknowledges within TIMEOUT cycles.
module calc_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT = 64,
  parameter logic [3:0] IDLE_CMD = 4'b1101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [1:0] core_status,
  input  logic       err_clear,
  output logic [3:0] cmd,
  output logic       seq_busy,
  output logic       err,
  output logic       overflow,
  output logic       dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);
  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RELEASE, ERROR} state_t;
  state_t state;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, cnt_nxt;
  logic [3:0] cur, hold;
  logic push, pop, go_err;
`ifdef CMDSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`else
  // Without the timeout option nothing can be dropped; TIMEOUT has no effect.
  assign dropped = (TIMEOUT < 0);
`endif
  always_comb begin
    go_err = state != ERROR && core_status == 2'b00;
    push = key_valid && key_ready && state != ERROR;
    pop = state == IDLE && count != '0 && core_status == 2'b10;
    cnt_nxt = count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock)
    if (push) mem[wptr] <= key_code;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd <= IDLE_CMD;
      key_ready <= 1'b1;
      seq_busy <= 1'b0;
      err <= 1'b0;
      overflow <= 1'b0;
      cur <= '0;
      hold <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
`ifdef CMDSEQ_TIMEOUT_EN
      tcnt <= '0;
      dropped <= 1'b0;
`endif
    end else begin
      seq_busy <= state != IDLE || count != '0;
      if (key_valid && !key_ready && state != ERROR) overflow <= 1'b1;
      // A core error beats every other transition and flushes the queue, including a push this cycle.
      if (go_err) begin
        state <= ERROR;
        cmd <= IDLE_CMD;
        err <= 1'b1;
        key_ready <= 1'b0;
        wptr <= '0;
        rptr <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop) rptr <= rptr + AW'(1);
        count <= cnt_nxt;
        key_ready <= state == ERROR ? err_clear : cnt_nxt != FULL;
        case (state)
          IDLE:
            if (pop) begin
              cur <= mem[rptr];
              hold <= 4'd1;
              state <= ISSUE;
            end
          ISSUE: begin
            cmd <= cur;
            if (hold == HOLD) begin
              state <= ACK;
`ifdef CMDSEQ_TIMEOUT_EN
              tcnt <= '0;
`endif
            end else hold <= hold + 4'd1;
          end
          ACK:
            if (core_status[0]) begin
              state <= RELEASE;
              cmd <= IDLE_CMD;
            end
`ifdef CMDSEQ_TIMEOUT_EN
            else if (tcnt == TLAST) begin
              dropped <= 1'b1;
              state <= RELEASE;
              cmd <= IDLE_CMD;
            end else tcnt <= tcnt + TW'(1);
`endif
          RELEASE:
            if (core_status == 2'b10) state <= IDLE;
          ERROR:
            if (err_clear) begin
              state <= IDLE;
              err <= 1'b0;
              overflow <= 1'b0;
`ifdef CMDSEQ_TIMEOUT_EN
              dropped <= 1'b0;
`endif
            end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed vector table plus hand-written multi-cycle sequences for calc_cmd_sequencer.
module tb_calc_cmd_sequencer;
  localparam logic [3:0] D = 4'b1101;
  logic clock = 1'b0, reset = 1'b0, key_valid = 1'b0, err_clear = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [1:0] core_status = 2'b10;
  logic key_ready, seq_busy, err, overflow, dropped;
  logic [3:0] cmd;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] codes[$];
  int holds[$];
  logic [3:0] last = D;
  int run = 0;
  typedef struct {
    logic kv; logic [3:0] code; logic [1:0] st; logic clr;
    logic [3:0] e_cmd; logic e_kr, e_busy, e_err, e_ovf;
  } vec_t;
  vec_t tbl[16];

  calc_cmd_sequencer dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .core_status(core_status), .err_clear(err_clear),
    .cmd(cmd), .seq_busy(seq_busy), .err(err), .overflow(overflow), .dropped(dropped)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cmd !== last) begin
      if (last != D) holds.push_back(run);
      codes.push_back(cmd);
      last = cmd;
      run = 1;
    end else run++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    key_valid = 1'b0;
    err_clear = 1'b0;
    core_status = 2'b10;
    tick;
    reset = 1'b0;
  endtask

  // Core model: busy one cycle after a code appears, ready again three cycles later.
  task automatic run_core(input int maxc);
    int bcnt = 0;
    bit seen = 1'b0;
    bit done = 1'b0;
    core_status = 2'b10;
    for (int c = 0; c < maxc && !done; c++) begin
      tick;
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) core_status = 2'b10;
      end else if (cmd != D && core_status == 2'b10) begin
        if (seen) begin
          core_status = 2'b01;
          bcnt = 3;
          seen = 1'b0;
        end else seen = 1'b1;
      end
      if (c > 2 && !seq_busy && cmd == D && core_status == 2'b10) done = 1'b1;
    end
    check("run_core_drains", done, 1);
  endtask

  initial begin
    int start, hstart, nd;
    logic [3:0] k1[4];
    logic [3:0] e1[8];
    logic [3:0] got;
    tbl[0]  = '{1'b1, 4'd3, 2'b10, 1'b0, D,    1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'd0, 2'b10, 1'b0, D,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd0, 2'b10, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 2'b10, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 2'b10, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 2'b11, 1'b0, D,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 2'b01, 1'b0, D,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 2'b10, 1'b0, D,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 2'b10, 1'b0, D,    1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'd9, 2'b10, 1'b0, D,    1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'd2, 2'b01, 1'b0, D,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 2'b00, 1'b0, D,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'd5, 2'b00, 1'b0, D,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'd0, 2'b10, 1'b1, D,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'd0, 2'b10, 1'b0, D,    1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd0, 2'b10, 1'b0, D,    1'b1, 1'b0, 1'b0, 1'b0};
    k1 = '{4'd3, 4'd10, 4'd4, 4'd14};
    e1 = '{4'd3, D, 4'd10, D, 4'd4, D, 4'd14, D};

    #1 reset = 1'b1;
    tick;
    check("reset_values", {cmd, key_ready, seq_busy, err, overflow, dropped}, {D, 5'b10000});
    reset = 1'b0;

    foreach (tbl[i]) begin
      key_valid = tbl[i].kv;
      key_code = tbl[i].code;
      core_status = tbl[i].st;
      err_clear = tbl[i].clr;
      tick;
      check($sformatf("vec%0d", i), {cmd, key_ready, seq_busy, err, overflow},
            {tbl[i].e_cmd, tbl[i].e_kr, tbl[i].e_busy, tbl[i].e_err, tbl[i].e_ovf});
    end

    do_reset;
    start = codes.size();
    hstart = holds.size();
    foreach (k1[i]) begin
      key_valid = 1'b1;
      key_code = k1[i];
      tick;
    end
    key_valid = 1'b0;
    run_core(300);
    for (int i = 0; i < 8; i++) begin
      got = (start + i < codes.size()) ? codes[start + i] : 4'hx;
      check($sformatf("seq_code%0d", i), got, e1[i]);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("hold_ge2_%0d", i), (hstart + i < holds.size()) && holds[hstart + i] >= 2, 1);
    check("seq_busy_idle", seq_busy, 0);

    do_reset;
    start = codes.size();
    core_status = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      key_valid = 1'b1;
      key_code = 4'(k);
      tick;
      if (k == 4) check("full_key_ready", key_ready, 0);
      if (k == 5) check("overflow_set", overflow, 1);
    end
    key_valid = 1'b0;
    run_core(400);
    nd = 0;
    for (int i = start; i < codes.size(); i++)
      if (codes[i] != D) begin
        check($sformatf("ovf_code%0d", nd), codes[i], 4'(nd + 1));
        nd++;
      end
    check("ovf_code_count", nd, 4);
    check("overflow_sticky", overflow, 1);

    do_reset;
    key_valid = 1'b1;
    key_code = 4'd7;
    tick;
    key_valid = 1'b0;
`ifdef CMDSEQ_TIMEOUT_EN
    for (int c = 0; c < 100 && !dropped; c++) tick;
    check("timeout_dropped", dropped, 1);
    tick;
    check("timeout_cmd_idle", cmd, D);
`else
    repeat (100) tick;
    check("no_timeout_cmd", cmd, 4'd7);
    check("no_timeout_dropped", dropped, 0);
`endif
    core_status = 2'b00;
    tick;
    check("err_set", {err, cmd, key_ready}, {1'b1, D, 1'b0});
    core_status = 2'b10;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    check("err_cleared", {err, key_ready, overflow, dropped}, 4'b0100);

    do_reset;
    key_valid = 1'b1;
    key_code = 4'd6;
    tick;
    key_code = 4'd8;
    tick;
    key_code = 4'd9;
    tick;
    key_code = 4'd2;
    #2 reset = 1'b1;
    #1 check("async_reset_values", {cmd, key_ready, seq_busy, err, overflow, dropped}, {D, 5'b10000});
    key_valid = 1'b0;
    tick;
    reset = 1'b0;
    start = codes.size();
    repeat (20) tick;
    nd = 0;
    for (int i = start; i < codes.size(); i++) if (codes[i] != D) nd++;
    check("no_issue_after_reset", nd, 0);
    check("reset_seq_busy", {seq_busy, cmd}, {1'b0, D});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
